// File: rtl/demux8_64bit_bank_pkg.sv
// Shared sizing constants and FSM state type for the 8-slot write demux.
package demux8_64bit_bank_pkg;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/demux8_64bit_bank_dec3to8.sv
// 3-bit index plus enable to one-hot 8-bit write enable (purely combinational).
module dec3to8
   import demux8_64bit_bank_pkg::*;
(
   input  logic [IDX_W-1:0] i_idx,
   input  logic             i_en,
   output logic [DEPTH-1:0] o_onehot
);

   // One-hot decode gated by enable
   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot[i_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/demux8_64bit_bank.sv
// Write-side bank: steers handshaked 64-bit words into eight registered slots,
// either by explicit index (IDLE) or by an auto-incrementing burst pointer.
module demux8_64bit_bank #(
   parameter int unsigned WIDTH = demux8_64bit_bank_pkg::WIDTH,
   parameter int unsigned DEPTH = demux8_64bit_bank_pkg::DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [2:0]             in_sel,
   input  logic                   in_burst,
   input  logic                   in_last,
   output logic [WIDTH*DEPTH-1:0] out_data,
   output logic [DEPTH-1:0]       out_valid,
   input  logic [DEPTH-1:0]       out_clr,
   output logic                   busy
);

   import demux8_64bit_bank_pkg::*;

   state_t           r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;

   logic [IDX_W-1:0] w_target;
   logic             w_accept;
   logic [DEPTH-1:0] w_we;

   // Target slot: explicit index in IDLE, burst pointer in BURST
   always_comb begin
      w_target = in_sel;
      if (r_state == BURST) begin
         w_target = r_ptr;
      end
   end

   // Ready when the target slot is free or being freed this very cycle
   always_comb begin
      in_ready = rst_n && (!r_valid[w_target] || out_clr[w_target]);
      w_accept = in_valid && in_ready;
   end

   dec3to8 u_dec (
      .i_idx   (w_target),
      .i_en    (w_accept),
      .o_onehot(w_we)
   );

   // Slot storage and valid flags; a write beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_we[k]) begin
               r_data[k]  <= in_data;
               r_valid[k] <= 1'b1;
            end else if (out_clr[k]) begin
               r_valid[k] <= 1'b0;
            end
         end
      end
   end

   // Burst FSM and pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept && in_burst) begin
                  r_ptr <= IDX_W'(in_sel + 3'd1);
                  // A single-beat burst (in_last on the start beat) stays in IDLE
                  if (!in_last) begin
                     r_state <= BURST;
                  end
               end
            end
            BURST: begin
               if (w_accept) begin
                  r_ptr <= IDX_W'(r_ptr + 3'd1);
                  if (in_last) begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Flatten slots onto the wide output bus
   always_comb begin
      out_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         out_data[k*WIDTH +: WIDTH] = r_data[k];
      end
   end

   assign out_valid = r_valid;
   assign busy      = (r_state == BURST);

endmodule
